// File: rtl/da2_axi_ctrl_pkg.sv
// Shared definitions for the Pmod DA2 AXI4-Lite controller:
// register offsets, register bit positions and AXI response codes.
package da2_axi_ctrl_pkg;

    localparam logic [3:0] OFFSET_CH0    = 4'h0;
    localparam logic [3:0] OFFSET_CH1    = 4'h4;
    localparam logic [3:0] OFFSET_STATUS = 4'h8;
    localparam logic [3:0] OFFSET_CONFIG = 4'hC;

    localparam int CFG_BUF_EN      = 0;
    localparam int CFG_REFRESH     = 1;
    localparam int CFG_PD_A        = 2;
    localparam int CFG_PD_B        = 4;
    localparam int CFG_REFRESH_ALL = 6;

    localparam int ST_BUSY         = 0;
    localparam int ST_DATA_INVALID = 1;
    localparam int ST_PENDING      = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [15:0] dac_frame(input logic [1:0] pd,
                                              input logic [11:0] code);
        return {2'b00, pd, code};
    endfunction

endpackage

// File: rtl/da2_spi_tx.sv
// Dual-lane 16-bit serialiser for the DAC121S101 pair: CS framing,
// SCK divider and two parallel MSB-first shift registers.
module da2_spi_tx #(
    parameter int SCK_DIV = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] frame_a,
    input  logic [15:0] frame_b,
    output logic        sck,
    output logic        cs,
    output logic        da,
    output logic        db,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_CS_GAP = 2'd2;

    localparam int CW = (SCK_DIV < 2) ? 1 : $clog2(SCK_DIV + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [5:0]    phase_q, phase_d;
    logic [15:0]   sr_a_q, sr_a_d;
    logic [15:0]   sr_b_q, sr_b_d;
    logic          sck_q, sck_d;
    logic          cs_q, cs_d;

    // phase 0 is a high lead-in after CS falls; odd phases are SCK low,
    // even phases SCK high; data advances on every low->high step.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        sr_a_d  = sr_a_q;
        sr_b_d  = sr_b_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cs_d    = 1'b0;
                    sck_d   = 1'b1;
                    sr_a_d  = frame_a;
                    sr_b_d  = frame_b;
                    div_d   = '0;
                    phase_d = '0;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (phase_q == 6'd32) begin
                        state_d = S_CS_GAP;
                        cs_d    = 1'b1;
                    end else begin
                        phase_d = phase_q + 6'd1;
                        if (phase_q[0]) begin
                            sck_d  = 1'b1;
                            sr_a_d = {sr_a_q[14:0], 1'b0};
                            sr_b_d = {sr_b_q[14:0], 1'b0};
                        end else begin
                            sck_d = 1'b0;
                        end
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            S_CS_GAP: begin
                if (div_q == CW'(1)) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            phase_q <= '0;
            sr_a_q  <= '0;
            sr_b_q  <= '0;
            sck_q   <= 1'b1;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            sr_a_q  <= sr_a_d;
            sr_b_q  <= sr_b_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
        end
    end

    assign sck  = sck_q;
    assign cs   = cs_q;
    assign da   = sr_a_q[15];
    assign db   = sr_b_q[15];
    assign busy = (state_q != S_IDLE);

endmodule

// File: rtl/da2_axi_ctrl.sv
// AXI4-Lite slave for the Digilent Pmod DA2 with immediate or
// buffered channel updates and merged transfer requests.
module da2_axi_ctrl #(
    parameter int DUAL_MODE          = 1,
    parameter int SCK_DIV            = 3,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            SCK,
    output logic                            CS,
    output logic                            DA,
    output logic                            DB
);
    import da2_axi_ctrl_pkg::*;

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam bit DUAL = (DUAL_MODE != 0);

    logic          rdy_en_q;
    logic          aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [11:0]   act_a_q, act_a_d, act_b_q, act_b_d;
    logic [11:0]   buf_a_q, buf_a_d, buf_b_q, buf_b_d;
    logic [1:0]    pd_a_q, pd_a_d, pd_b_q, pd_b_d;
    logic [1:0]    pda_act_q, pda_act_d, pdb_act_q, pdb_act_d;
    logic          buf_en_q, buf_en_d, ref_all_q, ref_all_d;
    logic          dinv_q, dinv_d, pend_q, pend_d;

    logic          we, wr_ch0, wr_ch1, wr_cfg, req, start;
    logic          ar_hs, rd_ok, tx_busy, tx_da, tx_db;
    logic          cfg_buf, cfg_all, pd_chg;
    logic [1:0]    cfg_pda, cfg_pdb;
    logic [11:0]   code;
    logic [DW-1:0] rd_val;
    logic          unused_ok;

    assign s_axi_awready = rdy_en_q & ~aw_lat_q & ~bvalid_q;
    assign s_axi_wready  = rdy_en_q & ~w_lat_q & ~bvalid_q;
    assign s_axi_arready = rdy_en_q & ~rvalid_q;

    assign we      = aw_lat_q & w_lat_q & ~bvalid_q;
    assign wr_ch0  = (awaddr_q == AW'(OFFSET_CH0));
    assign wr_ch1  = (awaddr_q == AW'(OFFSET_CH1)) && DUAL;
    assign wr_cfg  = (awaddr_q == AW'(OFFSET_CONFIG));
    assign code    = wdata_q[11:0];
    assign cfg_buf = wdata_q[CFG_BUF_EN];
    assign cfg_all = wdata_q[CFG_REFRESH_ALL];
    assign cfg_pda = wdata_q[CFG_PD_A+:2];
    assign cfg_pdb = wdata_q[CFG_PD_B+:2];
    assign pd_chg  = {cfg_pda, cfg_pdb} != {pda_act_q, pdb_act_q};
    assign ar_hs   = s_axi_arvalid & s_axi_arready;
    assign start   = pend_q & ~tx_busy;

    always_comb begin
        aw_lat_d = we ? 1'b0 : (aw_lat_q | (s_axi_awvalid & s_axi_awready));
        w_lat_d  = we ? 1'b0 : (w_lat_q | (s_axi_wvalid & s_axi_wready));
        awaddr_d = (s_axi_awvalid & s_axi_awready) ? s_axi_awaddr : awaddr_q;
        wdata_d  = (s_axi_wvalid & s_axi_wready) ? s_axi_wdata : wdata_q;
        bvalid_d = bvalid_q ? ~s_axi_bready : we;
        bresp_d  = bresp_q;
        if (we)
            bresp_d = (wr_ch0 | wr_ch1 | wr_cfg) ? RESP_OKAY : RESP_SLVERR;
    end

    // CH writes keep the buffer in step even when unbuffered, so a later
    // switch to buffered mode starts from the live codes.
    always_comb begin
        act_a_d   = act_a_q;
        act_b_d   = act_b_q;
        buf_a_d   = buf_a_q;
        buf_b_d   = buf_b_q;
        pd_a_d    = pd_a_q;
        pd_b_d    = pd_b_q;
        pda_act_d = pda_act_q;
        pdb_act_d = pdb_act_q;
        buf_en_d  = buf_en_q;
        ref_all_d = ref_all_q;
        dinv_d    = dinv_q;
        req       = 1'b0;
        if (we && wr_ch0) begin
            buf_a_d = code;
            if (code != act_a_q) begin
                if (buf_en_q) dinv_d = 1'b1;
                else begin act_a_d = code; req = 1'b1; end
            end
        end
        if (we && wr_ch1) begin
            buf_b_d = code;
            if (code != act_b_q) begin
                if (buf_en_q) dinv_d = 1'b1;
                else begin act_b_d = code; req = 1'b1; end
            end
        end
        if (we && wr_cfg) begin
            buf_en_d  = cfg_buf;
            ref_all_d = cfg_all;
            pd_a_d    = cfg_pda;
            pd_b_d    = cfg_pdb;
            if (pd_chg && cfg_buf) dinv_d = 1'b1;
            if (pd_chg && !cfg_buf) begin
                pda_act_d = cfg_pda;
                pdb_act_d = cfg_pdb;
                req       = 1'b1;
            end
            if (wdata_q[CFG_REFRESH]) begin
                if (cfg_buf) begin
                    act_a_d   = buf_a_q;
                    act_b_d   = buf_b_q;
                    pda_act_d = cfg_pda;
                    pdb_act_d = cfg_pdb;
                    dinv_d    = 1'b0;
                    if (pd_chg || cfg_all || buf_a_q != act_a_q ||
                        buf_b_q != act_b_q)
                        req = 1'b1;
                end else if (cfg_all) begin
                    req = 1'b1;
                end
            end
        end
        pend_d = (pend_q & ~start) | req;
    end

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        if (s_axi_araddr == AW'(OFFSET_CH0)) begin
            rd_val[11:0] = buf_en_q ? buf_a_q : act_a_q;
        end else if (s_axi_araddr == AW'(OFFSET_CH1) && DUAL) begin
            rd_val[11:0] = buf_en_q ? buf_b_q : act_b_q;
        end else if (s_axi_araddr == AW'(OFFSET_STATUS)) begin
            rd_val[ST_BUSY]         = tx_busy;
            rd_val[ST_DATA_INVALID] = dinv_q;
            rd_val[ST_PENDING]      = pend_q;
        end else if (s_axi_araddr == AW'(OFFSET_CONFIG)) begin
            rd_val[CFG_BUF_EN]      = buf_en_q;
            rd_val[CFG_PD_A+:2]     = pd_a_q;
            rd_val[CFG_PD_B+:2]     = pd_b_q;
            rd_val[CFG_REFRESH_ALL] = ref_all_q;
        end else begin
            rd_ok = 1'b0;
        end
        rvalid_d = rvalid_q ? ~s_axi_rready : ar_hs;
        rdata_d  = ar_hs ? rd_val : rdata_q;
        rresp_d  = ar_hs ? (rd_ok ? RESP_OKAY : RESP_SLVERR) : rresp_q;
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rdy_en_q  <= 1'b0;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            act_a_q   <= '0;
            act_b_q   <= '0;
            buf_a_q   <= '0;
            buf_b_q   <= '0;
            pd_a_q    <= '0;
            pd_b_q    <= '0;
            pda_act_q <= '0;
            pdb_act_q <= '0;
            buf_en_q  <= 1'b0;
            ref_all_q <= 1'b0;
            dinv_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            rdy_en_q  <= 1'b1;
            aw_lat_q  <= aw_lat_d;
            w_lat_q   <= w_lat_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            act_a_q   <= act_a_d;
            act_b_q   <= act_b_d;
            buf_a_q   <= buf_a_d;
            buf_b_q   <= buf_b_d;
            pd_a_q    <= pd_a_d;
            pd_b_q    <= pd_b_d;
            pda_act_q <= pda_act_d;
            pdb_act_q <= pdb_act_d;
            buf_en_q  <= buf_en_d;
            ref_all_q <= ref_all_d;
            dinv_q    <= dinv_d;
            pend_q    <= pend_d;
        end
    end

    da2_spi_tx #(.SCK_DIV(SCK_DIV)) u_tx (
        .clk     (s_axi_aclk),
        .rst     (s_axi_areset),
        .start   (start),
        .frame_a (dac_frame(pda_act_q, act_a_q)),
        .frame_b (DUAL ? dac_frame(pdb_act_q, act_b_q) : 16'h0000),
        .sck     (SCK),
        .cs      (CS),
        .da      (tx_da),
        .db      (tx_db),
        .busy    (tx_busy)
    );

    assign DA = tx_da;
    assign DB = DUAL ? tx_db : 1'b0;

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                         wdata_q[DW-1:12]};

endmodule

// File: tb/tb_da2_axi_ctrl.sv
// Directed bench for da2_axi_ctrl: AXI register access plus a frame
// monitor compared against a register-level model of the DAC updates.
module tb_da2_axi_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        SCK, CS, DA, DB;

    int errors = 0;
    int checks = 0;

    // model of the spec-visible state
    logic [11:0] m_act [2];
    logic [11:0] m_buf [2];
    logic [1:0]  m_pd_act [2];
    logic [1:0]  m_pd_cfg [2];
    logic        m_buf_en = 0, m_ref_all = 0, m_dinv = 0, m_pend = 0;

    // monitor state
    logic        prev_cs = 1, prev_sck = 1;
    int          nbits = 0, frames = 0;
    logic [15:0] cap_a = '0, cap_b = '0, exp_a = '0, exp_b = '0;
    logic [15:0] last_a = '0, last_b = '0;

    always #5 clk = ~clk;

    da2_axi_ctrl dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .SCK           (SCK),
        .CS            (CS),
        .DA            (DA),
        .DB            (DB)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [31:0] d);
        int ch;
        logic [1:0] npd [2];
        logic chg, diff;
        if (addr == 4'h0 || addr == 4'h4) begin
            ch = (addr == 4'h4) ? 1 : 0;
            m_buf[ch] = d[11:0];
            if (d[11:0] != m_act[ch]) begin
                if (m_buf_en) m_dinv = 1;
                else begin m_act[ch] = d[11:0]; m_pend = 1; end
            end
        end else if (addr == 4'hC) begin
            npd[0] = d[3:2];
            npd[1] = d[5:4];
            chg = (npd[0] != m_pd_act[0]) || (npd[1] != m_pd_act[1]);
            m_buf_en  = d[0];
            m_ref_all = d[6];
            m_pd_cfg  = npd;
            if (chg && m_buf_en) m_dinv = 1;
            if (chg && !m_buf_en) begin m_pd_act = npd; m_pend = 1; end
            if (d[1] && m_buf_en) begin
                diff = (m_buf[0] != m_act[0]) || (m_buf[1] != m_act[1]);
                if (chg || diff || m_ref_all) m_pend = 1;
                m_act    = m_buf;
                m_pd_act = npd;
                m_dinv   = 0;
            end else if (d[1] && m_ref_all) begin
                m_pend = 1;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        case (addr)
            4'h0: return {20'h0, m_buf_en ? m_buf[0] : m_act[0]};
            4'h4: return {20'h0, m_buf_en ? m_buf[1] : m_act[1]};
            4'h8: return {29'h0, 1'b0, m_dinv, 1'b0};
            4'hC: return {25'h0, m_ref_all, m_pd_cfg[1], m_pd_cfg[0],
                          1'b0, m_buf_en};
            default: return 32'h0;
        endcase
    endfunction

    // frame monitor: DAC samples on SCK falling edges while CS is low
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (prev_cs && !CS) begin
                check("frame_expected", {31'h0, m_pend}, 32'h1);
                exp_a  = {2'b00, m_pd_act[0], m_act[0]};
                exp_b  = {2'b00, m_pd_act[1], m_act[1]};
                m_pend = 0;
                nbits  = 0;
            end
            if (!CS && prev_sck && !SCK) begin
                cap_a = {cap_a[14:0], DA};
                cap_b = {cap_b[14:0], DB};
                nbits++;
            end
            if (!prev_cs && CS) begin
                check("frame_bits", nbits, 16);
                check("frame_a", {16'h0, cap_a}, {16'h0, exp_a});
                check("frame_b", {16'h0, cap_b}, {16'h0, exp_b});
                last_a = cap_a;
                last_b = cap_b;
                frames++;
            end
            if (CS) check("idle_lines", {29'h0, SCK, DA, DB}, 32'h4);
        end
        prev_cs  = CS;
        prev_sck = SCK;
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] d,
                             input int order, input int hold,
                             input logic [1:0] exp_resp, input string nm);
        logic aw_done, w_done, hs_aw, hs_w;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr  = addr;
        wdata   = d;
        awvalid = (order != 1);
        wvalid  = (order != 2);
        while (!(aw_done && w_done) && n < 20) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1; n++;
            if (hs_aw) begin awvalid = 0; aw_done = 1; end
            if (hs_w) begin wvalid = 0; w_done = 1; end
            if (w_done && !aw_done) awvalid = 1;
            if (aw_done && !w_done) wvalid = 1;
        end
        awvalid = 0; wvalid = 0;
        check({nm, "_handshake"}, {31'h0, aw_done && w_done}, 32'h1);
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        check({nm, "_bvalid"}, {31'h0, bvalid}, 32'h1);
        if (exp_resp == 2'b00) model_write(addr, d);
        check({nm, "_bresp"}, {30'h0, bresp}, {30'h0, exp_resp});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_bvalid_held"}, {31'h0, bvalid}, 32'h1);
            check({nm, "_awready_blocked"}, {31'h0, awready}, 32'h0);
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check({nm, "_bvalid_clear"}, {31'h0, bvalid}, 32'h0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_d,
                            input logic [1:0] exp_resp, input int hold,
                            input string nm);
        logic done;
        int n;
        done = 0; n = 0;
        araddr  = addr;
        arvalid = 1;
        while (!done && n < 20) begin
            done = arready;
            @(posedge clk); #1; n++;
        end
        arvalid = 0;
        check({nm, "_rvalid"}, {31'h0, rvalid}, 32'h1);
        check({nm, "_rdata"}, rdata, exp_d);
        check({nm, "_rresp"}, {30'h0, rresp}, {30'h0, exp_resp});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_rvalid_held"}, {31'h0, rvalid}, 32'h1);
            check({nm, "_arready_blocked"}, {31'h0, arready}, 32'h0);
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        check({nm, "_rvalid_clear"}, {31'h0, rvalid}, 32'h0);
    endtask

    task automatic wait_idle(input string nm);
        int n, quiet;
        n = 0; quiet = 0;
        while (!(m_pend == 0 && quiet >= 8) && n < 1000) begin
            @(posedge clk); #1; n++;
            quiet = CS ? quiet + 1 : 0;
        end
        check({nm, "_idle"}, {31'h0, n < 1000}, 32'h1);
    endtask

    initial begin
        int f0, n;
        m_act = '{12'h0, 12'h0};
        m_buf = '{12'h0, 12'h0};
        m_pd_act = '{2'b00, 2'b00};
        m_pd_cfg = '{2'b00, 2'b00};

        repeat (3) @(posedge clk);
        #1;
        check("rst_lines", {28'h0, CS, SCK, DA, DB}, 32'hC);
        check("rst_ready", {29'h0, awready, wready, arready}, 32'h0);
        check("rst_valid", {30'h0, bvalid, rvalid}, 32'h0);
        check("rst_resp", {28'h0, bresp, rresp}, 32'h0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        axi_read(4'h8, 32'h0, 2'b00, 0, "status_reset");
        axi_write(4'hC, 32'h1, 0, 0, 2'b00, "cfg_bufen");
        axi_read(4'hC, 32'h1, 2'b00, 0, "cfg_read1");
        axi_write(4'h8, 32'hFF, 0, 0, 2'b10, "wr_status");
        axi_read(4'h8, 32'h0, 2'b00, 0, "status_after_slverr");
        axi_read(4'hD, 32'h0, 2'b10, 0, "rd_bad_d");
        axi_read(4'h6, 32'h0, 2'b10, 0, "rd_bad_6");

        axi_write(4'hC, 32'h0, 1, 3, 2'b00, "cfg_data_first");
        axi_read(4'hC, 32'h0, 2'b00, 3, "cfg_rready_hold");

        f0 = frames;
        axi_write(4'h0, 32'h01A, 2, 2, 2'b00, "ch0_01a");
        wait_idle("ch0_01a");
        check("ch0_01a_frames", frames - f0, 1);
        check("ch0_01a_lit_a", {16'h0, last_a}, 32'h001A);
        check("ch0_01a_lit_b", {16'h0, last_b}, 32'h0000);
        axi_read(4'h0, model_read(4'h0), 2'b00, 0, "ch0_rd");

        f0 = frames;
        axi_write(4'h0, 32'h01A, 2, 0, 2'b00, "ch0_same");
        wait_idle("ch0_same");
        check("ch0_same_frames", frames - f0, 0);

        f0 = frames;
        axi_write(4'hC, 32'h8, 0, 0, 2'b00, "cfg_pd");
        wait_idle("cfg_pd");
        check("cfg_pd_frames", frames - f0, 1);
        check("cfg_pd_lit_a", {16'h0, last_a}, 32'h201A);

        f0 = frames;
        axi_write(4'hC, 32'h19, 0, 0, 2'b00, "cfg_buf");
        axi_write(4'h0, 32'hBCA, 0, 0, 2'b00, "buf_ch0");
        axi_write(4'h4, 32'hAF5, 1, 0, 2'b00, "buf_ch1");
        wait_idle("buffered");
        check("buffered_frames", frames - f0, 0);
        axi_read(4'h8, 32'h2, 2'b00, 0, "status_dinv");
        axi_read(4'h0, model_read(4'h0), 2'b00, 0, "buf_ch0_rd");
        axi_read(4'h4, 32'hAF5, 2'b00, 0, "buf_ch1_rd");

        f0 = frames;
        axi_write(4'hC, 32'h5B, 0, 0, 2'b00, "refresh");
        wait_idle("refresh");
        check("refresh_frames", frames - f0, 1);
        check("refresh_lit_a", {16'h0, last_a}, 32'h2BCA);
        check("refresh_lit_b", {16'h0, last_b}, 32'h1AF5);
        axi_read(4'h8, model_read(4'h8), 2'b00, 0, "status_clean");
        axi_read(4'hC, 32'h59, 2'b00, 0, "cfg_read_refresh");

        f0 = frames;
        axi_write(4'hC, 32'h0, 0, 0, 2'b00, "cfg_unbuf");
        wait_idle("cfg_unbuf");
        check("cfg_unbuf_frames", frames - f0, 1);

        f0 = frames;
        axi_write(4'h0, 32'h111, 0, 0, 2'b00, "busy_first");
        n = 0;
        while (CS && n < 50) begin @(posedge clk); #1; n++; end
        check("busy_started", {31'h0, CS}, 32'h0);
        axi_write(4'h0, 32'h222, 0, 0, 2'b00, "busy_second");
        axi_write(4'h0, 32'h333, 2, 0, 2'b00, "busy_third");
        axi_read(4'h8, 32'h5, 2'b00, 0, "status_busy_pend");
        wait_idle("busy");
        check("busy_frames", frames - f0, 2);
        check("busy_lit_a", {16'h0, last_a}, 32'h0333);
        check("busy_lit_b", {16'h0, last_b}, 32'h0AF5);

        f0 = frames;
        axi_write(4'hC, 32'h42, 0, 0, 2'b00, "force_all");
        wait_idle("force_all");
        check("force_all_frames", frames - f0, 1);
        check("force_all_lit_a", {16'h0, last_a}, 32'h0333);

        f0 = frames;
        axi_write(4'h3, 32'h777, 0, 0, 2'b10, "wr_unaligned");
        wait_idle("wr_unaligned");
        check("wr_unaligned_frames", frames - f0, 0);
        axi_read(4'h0, 32'h333, 2'b00, 0, "ch0_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
